// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC tag scheduler. The BIST states exist only when
// AXI_LLC_TAG_SCHED_BIST_EN is defined.
package axi_llc_pkg;

    typedef enum logic [1:0] {
        Bist   = 2'd0,
        Flush  = 2'd1,
        Lookup = 2'd2
    } tag_mode_t;

`ifdef AXI_LLC_TAG_SCHED_BIST_EN
    typedef enum logic [1:0] {
        BIST_REQ  = 2'd0,
        BIST_WAIT = 2'd1,
        IDLE      = 2'd2,
        FLUSH     = 2'd3
    } state_e;

    localparam state_e ResetState = BIST_REQ;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam state_e ResetState = IDLE;
`endif

endpackage

// File: rtl/axi_llc_tag_sched_if.sv
// Lookup-request and tag-store-request buses of the tag scheduler.
// slave = scheduler side, master = lookup source / tag store side.
interface axi_llc_tag_sched_if #(
    parameter int unsigned NumWays  = 8,
    parameter int unsigned NumLines = 256,
    parameter int unsigned TagW     = 20
) ();
    import axi_llc_pkg::*;

    localparam int unsigned IndexW = $clog2(NumLines);

    logic              lkp_valid_i;
    logic              lkp_ready_o;
    logic [IndexW-1:0] lkp_index_i;
    logic [TagW-1:0]   lkp_tag_i;
    logic              lkp_dirty_i;

    logic               req_valid_o;
    logic               req_ready_i;
    tag_mode_t          req_mode_o;
    logic [IndexW-1:0]  req_index_o;
    logic [TagW-1:0]    req_tag_o;
    logic               req_dirty_o;
    logic [NumWays-1:0] req_indicator_o;

    modport slave (
        input  lkp_valid_i, lkp_index_i, lkp_tag_i, lkp_dirty_i, req_ready_i,
        output lkp_ready_o, req_valid_o, req_mode_o, req_index_o, req_tag_o,
        output req_dirty_o, req_indicator_o
    );

    modport master (
        output lkp_valid_i, lkp_index_i, lkp_tag_i, lkp_dirty_i, req_ready_i,
        input  lkp_ready_o, req_valid_o, req_mode_o, req_index_o, req_tag_o,
        input  req_dirty_o, req_indicator_o
    );

endinterface

// File: rtl/axi_llc_tag_sched.sv
// LLC tag-store scheduler: BIST kick-off, lookup forwarding and way flushing.
// BIST support is compiled in with AXI_LLC_TAG_SCHED_BIST_EN.
module axi_llc_tag_sched #(
    parameter int unsigned NumWays  = 8,
    parameter int unsigned NumLines = 256,
    parameter int unsigned TagW     = 20
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumWays-1:0] spm_lock_i,
    input  logic [NumWays-1:0] flushed_i,
    input  logic               flush_valid_i,
    output logic               flush_ready_o,
    input  logic [NumWays-1:0] flush_ways_i,
    output logic               flush_done_o,
    input  logic               bist_valid_i,
    input  logic [NumWays-1:0] bist_res_i,
    output logic               bist_done_o,
    output logic [NumWays-1:0] bist_fail_o,
    output logic               busy_o,
    axi_llc_tag_sched_if.slave bus
);
    import axi_llc_pkg::*;

    localparam int unsigned       IndexW  = $clog2(NumLines);
    localparam logic [IndexW-1:0] LastIdx = IndexW'(NumLines - 1);

    state_e             state_q, state_d;
    logic               req_valid_q, req_valid_d;
    tag_mode_t          req_mode_q, req_mode_d;
    logic [IndexW-1:0]  req_index_q, req_index_d;
    logic [TagW-1:0]    req_tag_q, req_tag_d;
    logic               req_dirty_q, req_dirty_d;
    logic [NumWays-1:0] req_ind_q, req_ind_d;
    logic               flush_done_q, flush_done_d;
    logic [IndexW-1:0]  cnt_q, cnt_d;
    logic               all_issued_q, all_issued_d;
    logic [NumWays-1:0] mask_q, mask_d;
    logic               prio_q, prio_d;

    logic               held_hs, can_load, lkp_ready, flush_ready;
    logic               ld_lkp, ld_flush, ld_bist;
    logic [NumWays-1:0] flush_mask;

`ifdef AXI_LLC_TAG_SCHED_BIST_EN
    logic               bist_done_q, bist_done_d;
    logic [NumWays-1:0] bist_fail_q, bist_fail_d;
`endif

    assign held_hs    = req_valid_q & bus.req_ready_i;
    assign can_load   = ~req_valid_q | bus.req_ready_i;
    assign flush_mask = flush_ways_i & ~spm_lock_i;

    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q & ~held_hs;
        req_mode_d   = req_mode_q;
        req_index_d  = req_index_q;
        req_tag_d    = req_tag_q;
        req_dirty_d  = req_dirty_q;
        req_ind_d    = req_ind_q;
        flush_done_d = 1'b0;
        cnt_d        = cnt_q;
        all_issued_d = all_issued_q;
        mask_d       = mask_q;
        prio_d       = prio_q;
        lkp_ready    = 1'b0;
        flush_ready  = 1'b0;
        ld_lkp       = 1'b0;
        ld_flush     = 1'b0;
        ld_bist      = 1'b0;
`ifdef AXI_LLC_TAG_SCHED_BIST_EN
        bist_done_d  = bist_done_q;
        bist_fail_d  = bist_fail_q;
`endif

        case (state_q)
`ifdef AXI_LLC_TAG_SCHED_BIST_EN
            BIST_REQ: begin
                if (!req_valid_q)          ld_bist = 1'b1;
                else if (bus.req_ready_i)  state_d = BIST_WAIT;
            end
            BIST_WAIT: begin
                if (bist_valid_i) begin
                    bist_fail_d = bist_res_i;
                    bist_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            IDLE: begin
                flush_ready = 1'b1;
                if (flush_valid_i) begin
                    mask_d       = flush_mask;
                    cnt_d        = '0;
                    all_issued_d = 1'b0;
                    prio_d       = 1'b0;
                    if (flush_mask == '0) flush_done_d = 1'b1;
                    else                  state_d      = FLUSH;
                end else begin
                    lkp_ready = can_load;
                    ld_lkp    = can_load & bus.lkp_valid_i;
                end
            end
            FLUSH: begin
                if (held_hs && req_mode_q == Flush && req_index_q == LastIdx) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end
                // Lookups get a slot right after a flush slot, or freely once all indices are out.
                lkp_ready = can_load & (prio_q | all_issued_q);
                if (lkp_ready && bus.lkp_valid_i) begin
                    ld_lkp = 1'b1;
                    prio_d = 1'b0;
                end else if (can_load && !all_issued_q) begin
                    ld_flush = 1'b1;
                    prio_d   = 1'b1;
                    if (cnt_q == LastIdx) all_issued_d = 1'b1;
                    else                  cnt_d        = cnt_q + IndexW'(1);
                end
            end
            default: state_d = ResetState;
        endcase

        if (ld_lkp) begin
            req_valid_d = 1'b1;
            req_mode_d  = Lookup;
            req_index_d = bus.lkp_index_i;
            req_tag_d   = bus.lkp_tag_i;
            req_dirty_d = bus.lkp_dirty_i;
            req_ind_d   = ~(spm_lock_i | flushed_i);
        end else if (ld_flush) begin
            req_valid_d = 1'b1;
            req_mode_d  = Flush;
            req_index_d = cnt_q;
            req_tag_d   = '0;
            req_dirty_d = 1'b0;
            req_ind_d   = mask_q;
        end else if (ld_bist) begin
            req_valid_d = 1'b1;
            req_mode_d  = Bist;
            req_index_d = '0;
            req_tag_d   = '0;
            req_dirty_d = 1'b0;
            req_ind_d   = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ResetState;
            req_valid_q  <= 1'b0;
            req_mode_q   <= Lookup;
            req_index_q  <= '0;
            req_tag_q    <= '0;
            req_dirty_q  <= 1'b0;
            req_ind_q    <= '0;
            flush_done_q <= 1'b0;
            cnt_q        <= '0;
            all_issued_q <= 1'b0;
            mask_q       <= '0;
            prio_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_mode_q   <= req_mode_d;
            req_index_q  <= req_index_d;
            req_tag_q    <= req_tag_d;
            req_dirty_q  <= req_dirty_d;
            req_ind_q    <= req_ind_d;
            flush_done_q <= flush_done_d;
            cnt_q        <= cnt_d;
            all_issued_q <= all_issued_d;
            mask_q       <= mask_d;
            prio_q       <= prio_d;
        end
    end

`ifdef AXI_LLC_TAG_SCHED_BIST_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bist_done_q <= 1'b0;
            bist_fail_q <= '0;
        end else begin
            bist_done_q <= bist_done_d;
            bist_fail_q <= bist_fail_d;
        end
    end

    assign bist_done_o = bist_done_q;
    assign bist_fail_o = bist_fail_q;
`else
    logic unused_bist;
    assign unused_bist = ^{bist_valid_i, bist_res_i};
    assign bist_done_o = 1'b1;
    assign bist_fail_o = '0;
`endif

    assign bus.lkp_ready_o     = lkp_ready;
    assign bus.req_valid_o     = req_valid_q;
    assign bus.req_mode_o      = req_mode_q;
    assign bus.req_index_o     = req_index_q;
    assign bus.req_tag_o       = req_tag_q;
    assign bus.req_dirty_o     = req_dirty_q;
    assign bus.req_indicator_o = req_ind_q;
    assign flush_ready_o       = flush_ready;
    assign flush_done_o        = flush_done_q;
    assign busy_o              = (state_q != IDLE) | req_valid_q;

endmodule

// File: tb/tb_axi_llc_tag_sched.sv
// Scoreboard bench for axi_llc_tag_sched; covers the BIST path when
// AXI_LLC_TAG_SCHED_BIST_EN is defined.
module tb_axi_llc_tag_sched;
    import axi_llc_pkg::*;

    localparam int NW = 8;
    localparam int NL = 256;
    localparam int TW = 20;
    localparam int IW = 8;
    localparam int PW = 2 + IW + TW + 1 + NW;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic          dirty;
        logic [NW-1:0] ind;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NW-1:0] spm_lock_i, flushed_i, flush_ways_i, bist_res_i, bist_fail_o;
    logic          flush_valid_i, flush_ready_o, flush_done_o;
    logic          bist_valid_i, bist_done_o, busy_o;

    axi_llc_tag_sched_if #(.NumWays(NW), .NumLines(NL), .TagW(TW)) bus ();

    axi_llc_tag_sched #(.NumWays(NW), .NumLines(NL), .TagW(TW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .spm_lock_i    (spm_lock_i),
        .flushed_i     (flushed_i),
        .flush_valid_i (flush_valid_i),
        .flush_ready_o (flush_ready_o),
        .flush_ways_i  (flush_ways_i),
        .flush_done_o  (flush_done_o),
        .bist_valid_i  (bist_valid_i),
        .bist_res_i    (bist_res_i),
        .bist_done_o   (bist_done_o),
        .bist_fail_o   (bist_fail_o),
        .busy_o        (busy_o),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int        total = 0, bad = 0;
    exp_t      lkq[$], fq[$];
    int        bist_exp = 0;
    int        done_due = -1, done_cnt = 0, flush_seen = 0;
    tag_mode_t mlog[$];
    bit        log_en = 0;
    bit        lkp_hs, flush_hs;
    bit        prev_stall = 0;
    logic [PW-1:0] prev_pl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: record what each accepted command must produce.
    task automatic step();
        logic [NW-1:0] m;
        @(negedge clk_i);
        lkp_hs   = bus.lkp_valid_i && bus.lkp_ready_o;
        flush_hs = flush_valid_i && flush_ready_o;
        if (lkp_hs)
            lkq.push_back('{bus.lkp_index_i, bus.lkp_tag_i, bus.lkp_dirty_i, ~(spm_lock_i | flushed_i)});
        if (flush_hs) begin
            m = flush_ways_i & ~spm_lock_i;
            if (m == '0) done_due = cyc + 1;
            else for (int i = 0; i < NL; i++) fq.push_back('{IW'(i), '0, 1'b0, m});
        end
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compares every tag-store handshake against the expectation queues.
    always @(negedge clk_i) begin
        logic [PW-1:0] pl;
        exp_t e, a;
        pl = {bus.req_mode_o, bus.req_index_o, bus.req_tag_o, bus.req_dirty_o, bus.req_indicator_o};
        a  = '{bus.req_index_o, bus.req_tag_o, bus.req_dirty_o, bus.req_indicator_o};
        if (rst_i) begin
            lkq.delete();
            fq.delete();
            done_due   = -1;
            prev_stall = 0;
        end else begin
            if (flush_done_o || done_due == cyc) chk("flush_done_timing", 64'(flush_done_o), 64'(done_due == cyc));
            if (flush_done_o) begin
                done_cnt++;
                log_en = 0;
            end
            if (prev_stall) begin
                chk("stall_valid_held", 64'(bus.req_valid_o), 64'd1);
                chk("stall_payload", 64'(pl), 64'(prev_pl));
            end
            prev_stall = bus.req_valid_o && !bus.req_ready_i;
            prev_pl    = pl;
            if (bus.req_valid_o && bus.req_ready_i) begin
                if (log_en) mlog.push_back(bus.req_mode_o);
                case (bus.req_mode_o)
                    Lookup: begin
                        chk("lookup_expected", 64'(lkq.size() > 0), 64'd1);
                        if (lkq.size() > 0) begin
                            e = lkq.pop_front();
                            chk("lookup_payload", 64'(a), 64'(e));
                        end
                    end
                    Flush: begin
                        flush_seen++;
                        chk("flush_expected", 64'(fq.size() > 0), 64'd1);
                        if (fq.size() > 0) begin
                            e = fq.pop_front();
                            chk("flush_index", 64'(bus.req_index_o), 64'(e.idx));
                            chk("flush_mask", 64'(bus.req_indicator_o), 64'(e.ind));
                            if (e.idx == IW'(NL - 1)) done_due = cyc + 1;
                        end
                    end
                    default: begin
                        chk("bist_expected", 64'(bist_exp), 64'd1);
                        chk("bist_indicator", 64'(bus.req_indicator_o), 64'({NW{1'b1}}));
                        bist_exp = 0;
                    end
                endcase
            end
        end
    end

    task automatic rand_lkp();
        bus.lkp_valid_i = 1'($urandom_range(0, 1));
        bus.lkp_index_i = IW'($urandom);
        bus.lkp_tag_i   = TW'($urandom);
        bus.lkp_dirty_i = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.lkp_valid_i = 1'b0;
        flush_valid_i = 1'b0;
        bist_valid_i = 1'b0;
        step();
        step();
        chk("rst_req_valid", 64'(bus.req_valid_o), 64'd0);
        chk("rst_flush_done", 64'(flush_done_o), 64'd0);
        chk("rst_bist_fail", 64'(bist_fail_o), 64'd0);
`ifdef AXI_LLC_TAG_SCHED_BIST_EN
        chk("rst_bist_done", 64'(bist_done_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b0;
        bist_exp = 1;
        bus.req_ready_i = 1'b1;
        step();
        chk("bist_lkp_ready", 64'(bus.lkp_ready_o), 64'd0);
        chk("bist_flush_ready", 64'(flush_ready_o), 64'd0);
        repeat (10) step();
        bist_valid_i = 1'b1;
        bist_res_i   = 8'h04;
        step();
        bist_valid_i = 1'b0;
        bist_res_i   = 8'h00;
        step();
        chk("bist_done", 64'(bist_done_o), 64'd1);
        chk("bist_fail", 64'(bist_fail_o), 64'h04);
        chk("bist_req_consumed", 64'(bist_exp), 64'd0);
        chk("bist_idle", 64'(busy_o), 64'd0);
`else
        chk("rst_bist_done", 64'(bist_done_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        step();
`endif
    endtask

    task automatic drain();
        bus.lkp_valid_i = 1'b0;
        flush_valid_i   = 1'b0;
        bus.req_ready_i = 1'b1;
        for (int n = 0; n < 50 && (lkq.size() + fq.size()) > 0; n++) step();
        step();
        chk("drain_empty", 64'(lkq.size() + fq.size()), 64'd0);
    endtask

    task automatic wait_done(input int bound, input bit rnd);
        int d0;
        d0 = done_cnt;
        for (int n = 0; n < bound && done_cnt == d0; n++) begin
            if (rnd) begin
                rand_lkp();
                bus.req_ready_i = ($urandom_range(0, 3) != 0);
            end else if (bus.lkp_valid_i) begin
                bus.lkp_index_i = IW'($urandom);
                bus.lkp_tag_i   = TW'($urandom);
            end
            step();
        end
        chk("flush_finished", 64'(done_cnt != d0), 64'd1);
    endtask

    initial begin
        int d0, f0, nl, nf, adj;
        rst_i = 1'b1;
        spm_lock_i = '0; flushed_i = '0; flush_ways_i = '0; flush_valid_i = 1'b0;
        bist_valid_i = 1'b0; bist_res_i = '0;
        bus.lkp_valid_i = 1'b0; bus.lkp_index_i = '0; bus.lkp_tag_i = '0; bus.lkp_dirty_i = 1'b0;
        bus.req_ready_i = 1'b1;
        do_reset();

        // Single lookup: one-cycle latency, SPM ways excluded from the indicator.
        spm_lock_i = 8'h81; flushed_i = 8'h00;
        bus.lkp_valid_i = 1'b1; bus.lkp_index_i = 8'd5; bus.lkp_tag_i = 20'h123; bus.lkp_dirty_i = 1'b0;
        step();
        chk("lkp_accepted", 64'(lkp_hs), 64'd1);
        bus.lkp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("lkp_latency_valid", 64'(bus.req_valid_o), 64'd1);
        chk("lkp_mode", 64'(bus.req_mode_o), 64'(Lookup));
        chk("lkp_indicator", 64'(bus.req_indicator_o), 64'h7E);
        @(posedge clk_i); #1;
        step();
        chk("idle_not_busy", 64'(busy_o), 64'd0);

        // Random lookups against a randomly stalling tag store.
        for (int n = 0; n < 300; n++) begin
            rand_lkp();
            spm_lock_i = NW'($urandom);
            flushed_i  = NW'($urandom);
            bus.req_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Full flush of ways 0..3, no lookups.
        spm_lock_i = '0; flushed_i = '0; flush_ways_i = 8'h0F; flush_valid_i = 1'b1;
        d0 = done_cnt; f0 = flush_seen;
        step();
        chk("flush_accepted", 64'(flush_hs), 64'd1);
        flush_valid_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd1);
        chk("flush_ready_low", 64'(flush_ready_o), 64'd0);
        wait_done(600, 0);
        repeat (3) step();
        chk("flush_req_count", 64'(flush_seen - f0), 64'd256);
        chk("flush_done_once", 64'(done_cnt - d0), 64'd1);

        // Flush fully masked by SPM: done pulse only.
        spm_lock_i = 8'h03; flush_ways_i = 8'h03; flush_valid_i = 1'b1;
        d0 = done_cnt; f0 = flush_seen;
        step();
        flush_valid_i = 1'b0;
        repeat (3) step();
        chk("spm_flush_no_req", 64'(flush_seen - f0), 64'd0);
        chk("spm_flush_done", 64'(done_cnt - d0), 64'd1);

        // Flush with lookups held valid: slots must alternate.
        spm_lock_i = '0; flush_ways_i = 8'hFF; flush_valid_i = 1'b1;
        mlog.delete(); log_en = 1;
        step();
        flush_valid_i = 1'b0;
        bus.lkp_valid_i = 1'b1;
        wait_done(1500, 0);
        bus.lkp_valid_i = 1'b0;
        log_en = 0;
        nl = 0; nf = 0; adj = 0;
        foreach (mlog[i]) begin
            if (mlog[i] == Lookup) nl++;
            if (mlog[i] == Flush)  nf++;
            if (i > 0 && mlog[i] == mlog[i-1]) adj++;
        end
        chk("alt_first_flush", 64'(mlog.size() > 0 && mlog[0] == Flush), 64'd1);
        chk("alt_no_repeat", 64'(adj), 64'd0);
        chk("alt_flush_cnt", 64'(nf), 64'd256);
        chk("alt_lookup_cnt", 64'(nl), 64'd255);
        drain();

        // Flush with random lookups and random back-pressure.
        spm_lock_i = NW'($urandom); flush_ways_i = NW'($urandom) | 8'h10; spm_lock_i[4] = 1'b0;
        flush_valid_i = 1'b1;
        step();
        flush_valid_i = 1'b0;
        wait_done(3000, 1);
        drain();

        // Stall mid-flush, then reset: abandoned without a done pulse.
        spm_lock_i = '0; flush_ways_i = 8'hFF; flush_valid_i = 1'b1;
        step();
        flush_valid_i = 1'b0;
        repeat (20) step();
        bus.req_ready_i = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("stall_req_valid", 64'(bus.req_valid_o), 64'd1);
            chk("stall_flush_ready", 64'(flush_ready_o), 64'd0);
        end
        d0 = done_cnt;
        do_reset();
        chk("post_rst_valid", 64'(bus.req_valid_o), 64'd0);
        bus.req_ready_i = 1'b1;
        repeat (10) step();
        chk("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("post_rst_idle", 64'(busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
